// File: rtl/noc_out_pkt_arbiter_if.sv
// Handshake bundle between packet sources and the shared NoC output VC.
// slave = arbiter side, master = source/sink side.
interface noc_out_pkt_arbiter_if #(
   parameter int FLIT_WIDTH = 34,
   parameter int NUM_PORTS  = 3
);
   logic [NUM_PORTS*FLIT_WIDTH-1:0] in_flit;
   logic [NUM_PORTS-1:0]            in_valid;
   logic [NUM_PORTS-1:0]            in_ready;
   logic [FLIT_WIDTH-1:0]           out_flit;
   logic                            out_valid;
   logic                            out_ready;

   modport master (
      output in_flit, in_valid, out_ready,
      input  in_ready, out_flit, out_valid
   );

   modport slave (
      input  in_flit, in_valid, out_ready,
      output in_ready, out_flit, out_valid
   );
endinterface

// File: rtl/noc_out_pkt_arbiter.sv
// Packet-atomic round-robin arbiter feeding one NoC output VC through a
// single registered stage; the winner keeps the link until its tail flit.
module noc_out_pkt_arbiter #(
   parameter int FLIT_WIDTH = 34,
   parameter int NUM_PORTS  = 3,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   noc_out_pkt_arbiter_if.slave bus,
   output logic [NUM_PORTS-1:0] grant,
   output logic [CNT_WIDTH-1:0] pkt_count,
   output logic                 err_proto
);
   localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int LAST_BIT  = FLIT_WIDTH - 1;
   localparam int FIRST_BIT = FLIT_WIDTH - 2;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [0:0]            state;
   logic [PW-1:0]         rr_ptr;
   logic [PW-1:0]         owner;
   logic [PW-1:0]         sel;
   logic [PW-1:0]         next_ptr;
   logic                  sel_valid;
   logic                  load;
   logic                  accept;
   logic [FLIT_WIDTH-1:0] sel_flit;

   // Descending scan so the port closest to rr_ptr is assigned last and wins.
   always_comb begin
      sel       = owner;
      sel_valid = bus.in_valid[owner];
      if (state == IDLE) begin
         sel       = rr_ptr;
         sel_valid = 1'b0;
         for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (bus.in_valid[(int'(rr_ptr) + i) % NUM_PORTS]) begin
               sel       = PW'((int'(rr_ptr) + i) % NUM_PORTS);
               sel_valid = 1'b1;
            end
         end
      end
   end

   assign load     = !bus.out_valid || bus.out_ready;
   assign accept   = load && sel_valid;
   assign sel_flit = bus.in_flit[sel*FLIT_WIDTH +: FLIT_WIDTH];
   assign next_ptr = (sel == PW'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;

   // A locked owner sees ready even while idle; nobody sees ready during reset.
   always_comb begin
      bus.in_ready = '0;
      if (rst_n && load && (state == LOCKED || sel_valid)) begin
         bus.in_ready[sel] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_flit  <= '0;
         bus.out_valid <= 1'b0;
         pkt_count     <= '0;
      end else begin
         if (accept) begin
            bus.out_flit  <= sel_flit;
            bus.out_valid <= 1'b1;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
         if (bus.out_valid && bus.out_ready && bus.out_flit[LAST_BIT]) begin
            pkt_count <= pkt_count + 1'b1;
         end
      end
   end

   // Bad framing is flagged but the flit is still forwarded untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         grant     <= '0;
         err_proto <= 1'b0;
      end else if (accept) begin
         if (state == IDLE) begin
            if (!sel_flit[FIRST_BIT]) begin
               err_proto <= 1'b1;
            end
            if (sel_flit[LAST_BIT]) begin
               rr_ptr <= next_ptr;
            end else begin
               state <= LOCKED;
               owner <= sel;
               grant <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << sel;
            end
         end else begin
            if (sel_flit[FIRST_BIT] && !sel_flit[LAST_BIT]) begin
               err_proto <= 1'b1;
            end
            if (sel_flit[LAST_BIT]) begin
               state  <= IDLE;
               grant  <= '0;
               rr_ptr <= next_ptr;
            end
         end
      end
   end
endmodule
